tdm_demux16: RTL and testbench

//  Time-division 1-to-16 demultiplexer and the write-side counterpart of the 16:1 channel mux.
//  A serial beat stream (din, din_valid) is distributed into 16 registered channel slots w[15:0].

---
 rtl/tdm_demux_pkg.sv | 15 +
 rtl/tdm_demux16_dec.sv | 27 ++
 rtl/tdm_demux16.sv | 97 +++++++++
 tb/tb_tdm_demux16.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM demultiplexer and its 16:1 mux counterpart:
// FSM encoding, channel count and slot-address width.
package tdm_demux_pkg;

    localparam int unsigned NCH     = 16;
    localparam int unsigned SLOT_AW = 4;

    // 2'd3 is unused and treated as illegal: the FSM recovers to IDLE from it
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/tdm_demux16_dec.sv
// 4->16 one-hot decoder with enable, built as two 2->4 stages whose outputs
// are ANDed pairwise (mirror of the 16:1 mux tree).
module dec4to16
    import tdm_demux_pkg::*;
(
    input  logic [SLOT_AW-1:0] addr,
    input  logic               en,
    output logic [NCH-1:0]     onehot
);

    logic [3:0] hi;
    logic [3:0] lo;

    always_comb begin
        hi = '0;
        lo = '0;
        onehot = '0;
        hi[addr[3:2]] = en;
        lo[addr[1:0]] = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            for (int unsigned j = 0; j < 4; j++) begin
                onehot[i*4 + j] = hi[i] & lo[j];
            end
        end
    end

endmodule

// File: rtl/tdm_demux16.sv
// Time-division 1-to-16 demultiplexer: addressed single-slot writes in IDLE,
// in-order frame fill of slots 0..15 followed by a one-cycle frame_valid pulse.
module tdm_demux16
    import tdm_demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic [SLOT_AW-1:0]   s,
    input  logic                 start,
    output logic [NCH*WIDTH-1:0] w,
    output logic [NCH-1:0]       wr_onehot,
    output logic                 busy,
    output logic                 frame_valid
);

    state_t             state_q, state_d;
    logic [SLOT_AW-1:0] ptr_q, ptr_d;
    logic [SLOT_AW-1:0] dec_addr;
    logic               dec_en;
    logic [NCH-1:0]     slot_we;

    dec4to16 u_dec (
        .addr   (dec_addr),
        .en     (dec_en),
        .onehot (slot_we)
    );

    // start always wins over a coincident beat, in both IDLE and FILL
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        dec_addr = s;
        dec_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FILL;
                    ptr_d   = '0;
                end else if (din_valid) begin
                    dec_en = 1'b1;
                end
            end
            FILL: begin
                dec_addr = ptr_q;
                if (start) begin
                    ptr_d = '0;
                end else if (din_valid) begin
                    dec_en = 1'b1;
                    ptr_d  = ptr_q + 1'b1;
                    if (ptr_q == '1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            wr_onehot   <= '0;
            busy        <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            wr_onehot   <= slot_we;
            busy        <= (state_d == FILL) || (state_d == DONE);
            frame_valid <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w <= '0;
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                if (slot_we[k]) begin
                    w[k*WIDTH +: WIDTH] <= din;
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux16.sv
// Directed self-checking bench for tdm_demux16 (WIDTH=1).
module tb_tdm_demux16;

    logic        clk;
    logic        resetn;
    logic        din;
    logic        din_valid;
    logic [3:0]  s;
    logic        start;
    logic [15:0] w;
    logic [15:0] wr_onehot;
    logic        busy;
    logic        frame_valid;

    int unsigned checks = 0;
    int unsigned errors = 0;

    tdm_demux16 #(.WIDTH(1)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .din         (din),
        .din_valid   (din_valid),
        .s           (s),
        .start       (start),
        .w           (w),
        .wr_onehot   (wr_onehot),
        .busy        (busy),
        .frame_valid (frame_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h need %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // start cycle, then 16 beats of pat (LSB first), optional idle gap every
    // 3rd cycle, then the DONE cycle and the return to IDLE
    task automatic run_frame(input logic [15:0] pat, input bit gaps,
                             input bit start_beat, input bit done_beat);
        logic [15:0] w_before;
        logic [15:0] exp_oh;
        int unsigned b;
        int unsigned cyc;
        int unsigned busy_cnt;
        int unsigned fv_cnt;
        int unsigned ngaps;
        bit          fv_ok;
        w_before  = w;
        start     = 1'b1;
        din_valid = start_beat;
        din       = 1'b1;
        step();
        start = 1'b0;
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_no_write", {16'd0, w}, {16'd0, w_before});
        check("start_onehot", {16'd0, wr_onehot}, 32'd0);
        busy_cnt = 1;
        fv_cnt   = 0;
        ngaps    = 0;
        fv_ok    = 1'b0;
        b        = 0;
        cyc      = 0;
        while (b < 16) begin
            if (gaps && (cyc % 3 == 2)) begin
                din_valid = 1'b0;
                din       = 1'b1;
                exp_oh    = '0;
                ngaps++;
            end else begin
                din_valid = 1'b1;
                din       = pat[b];
                exp_oh    = 16'd1 << b;
                b++;
            end
            cyc++;
            step();
            if (exp_oh != 16'd0 || cyc % 6 == 3)
                check("fill_onehot", {16'd0, wr_onehot}, {16'd0, exp_oh});
            if (busy) busy_cnt++;
            if (frame_valid) begin
                fv_cnt++;
                if (b == 16) fv_ok = 1'b1;
            end
        end
        // DONE cycle: any beat offered here must be lost
        din_valid = done_beat;
        din       = 1'b1;
        step();
        din_valid = 1'b0;
        if (busy) busy_cnt++;
        if (frame_valid) fv_cnt++;
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_onehot", {16'd0, wr_onehot}, 32'd0);
        check("frame_w", {16'd0, w}, {16'd0, pat});
        check("fv_count", fv_cnt, 32'd1);
        check("fv_after_16th", {31'd0, fv_ok}, 32'd1);
        check("busy_cycles", busy_cnt, 32'd17 + ngaps);
    endtask

    initial begin
        resetn    = 1'b0;
        din       = 1'b0;
        din_valid = 1'b0;
        s         = 4'h0;
        start     = 1'b0;
        #23;
        check("rst_w", {16'd0, w}, 32'd0);
        check("rst_onehot", {16'd0, wr_onehot}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_fv", {31'd0, frame_valid}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        step();

        // addressed write to slot 10
        s = 4'hA; din = 1'b1; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        check("addr_w", {16'd0, w}, 32'h0400);
        check("addr_onehot", {16'd0, wr_onehot}, 32'h0400);
        check("addr_busy", {31'd0, busy}, 32'd0);
        s = 4'h3; din = 1'b0; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        check("addr0_w", {16'd0, w}, 32'h0400);
        check("addr0_onehot", {16'd0, wr_onehot}, 32'h0008);
        step();
        check("addr_idle_onehot", {16'd0, wr_onehot}, 32'd0);

        // gap-free and gapped frames
        s = 4'hA;
        run_frame(16'hA5C3, 1'b0, 1'b0, 1'b0);
        run_frame(16'h3C5A, 1'b1, 1'b0, 1'b0);

        // restart after 5 beats of an all-ones frame, from w=0
        resetn = 1'b0;
        #1;
        resetn = 1'b1;
        check("reset2_w", {16'd0, w}, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din = 1'b1; din_valid = 1'b1;
            step();
            check("partial_fv", {31'd0, frame_valid}, 32'd0);
        end
        din_valid = 1'b0;
        check("partial_w", {16'd0, w}, 32'h001F);
        run_frame(16'h1234, 1'b0, 1'b1, 1'b0);

        // start+beat in IDLE (s=6, slot 6 of 0x1234 is 0) and a beat in DONE
        s = 4'h6;
        run_frame(16'h0F0F, 1'b0, 1'b1, 1'b1);
        step();
        check("done_beat_lost", {16'd0, w}, 32'h0F0F);

        // reset in the middle of a fill
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            din = 1'b1; din_valid = 1'b1;
            step();
        end
        check("pre_reset_w", {16'd0, w}, 32'h0F3F);
        resetn = 1'b0;
        #1;
        check("midrst_w", {16'd0, w}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_fv", {31'd0, frame_valid}, 32'd0);
        check("midrst_onehot", {16'd0, wr_onehot}, 32'd0);
        din_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        step();
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
